regfile_8x16_wb: RTL and testbench

// - 8-entry x 16-bit register bank with a staged write port, two combinational

---
 rtl/regfile_8x16_wb.sv | 148 ++++++++++++++
 tb/tb_regfile_8x16_wb.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_8x16_wb.sv
// regfile_8x16_wb
// 8 x 16-bit register bank feeding the downstream 8:1 read muxes.
// Writes pass through a one-entry staging register that is bypassed to both
// read ports, so a read in the cycle after an accepted write already sees the
// new value. A clear request starts an 8-cycle sweep that zeroes one register
// per cycle while the write port is held off.

module regfile_8x16_wb #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [2:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr_req,
  output logic             clr_busy,
  input  logic [2:0]       rd_a_sel,
  output logic [WIDTH-1:0] rd_a_data,
  input  logic [2:0]       rd_b_sel,
  output logic [WIDTH-1:0] rd_b_data
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_cnt;
  logic [2:0]       w_cnt_nxt;
  logic             w_wr_ready;
  logic             w_clr_busy;
  logic             w_wr_accept;

  logic [WIDTH-1:0] r_regs [NREG];

  logic             r_pend_v;
  logic [2:0]       r_pend_addr;
  logic [WIDTH-1:0] r_pend_data;

  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;

  assign w_wr_accept = wr_valid & w_wr_ready;

  // Sweep controller state and counter registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic and port handshakes; the sweep exits as cnt wraps 7 -> 0.
  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wr_ready  = 1'b1;
    w_clr_busy  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (clr_req) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = 3'd0;
        end
      end
      ST_CLEAR: begin
        w_wr_ready = 1'b0;
        w_clr_busy = 1'b1;
        w_cnt_nxt  = r_cnt + 3'd1;
        if (r_cnt == 3'd7) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  // Write staging register: loads on an accepted write, otherwise drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_v    <= 1'b0;
      r_pend_addr <= 3'd0;
      r_pend_data <= '0;
    end else begin
      r_pend_v <= w_wr_accept;
      if (w_wr_accept) begin
        r_pend_addr <= wr_addr;
        r_pend_data <= wr_data;
      end
    end
  end

  // Register bank: commit the staged entry, then let the sweep overwrite it so
  // the clear wins when both target the same register on the same edge.
  // NOTE: the bank is reset because the reads must return 0 right after reset;
  // this makes it plain flops rather than a RAM macro, which is fine at 8x16.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (r_pend_v) begin
        r_regs[r_pend_addr] <= r_pend_data;
      end
      if (w_clr_busy) begin
        r_regs[r_cnt] <= '0;
      end
    end
  end

  // Read port A with bypass from the staging register.
  always_comb begin
    w_rd_a = r_regs[rd_a_sel];
    if (r_pend_v && (r_pend_addr == rd_a_sel)) begin
      w_rd_a = r_pend_data;
    end
  end

  // Read port B with bypass from the staging register.
  always_comb begin
    w_rd_b = r_regs[rd_b_sel];
    if (r_pend_v && (r_pend_addr == rd_b_sel)) begin
      w_rd_b = r_pend_data;
    end
  end

  assign wr_ready  = w_wr_ready;
  assign clr_busy  = w_clr_busy;
  assign rd_a_data = w_rd_a;
  assign rd_b_data = w_rd_b;

endmodule

// File: tb/tb_regfile_8x16_wb.sv
// tb_regfile_8x16_wb
// Table-driven vectors for the write/bypass behaviour, hand sequences for the
// clear sweep and reset-during-sweep, then random traffic against a model
// that tracks only the architecturally visible register values.

module tb_regfile_8x16_wb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [2:0]  wr_addr = 3'd0;
  logic [15:0] wr_data = 16'h0;
  logic        clr_req = 1'b0;
  logic        clr_busy;
  logic [2:0]  rd_a_sel = 3'd0;
  logic [15:0] rd_a_data;
  logic [2:0]  rd_b_sel = 3'd0;
  logic [15:0] rd_b_data;

  regfile_8x16_wb dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .rd_a_sel (rd_a_sel),
    .rd_a_data(rd_a_data),
    .rd_b_sel (rd_b_sel),
    .rd_b_data(rd_b_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wv;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [2:0]  as;
    logic [2:0]  bs;
    logic [15:0] ea;
    logic [15:0] eb;
    logic        er;
  } vec_t;

  vec_t        vecs[$];
  int          n_vec = 0;
  int          n_err = 0;

  // Visible-value model: a write is visible from the edge that accepts it;
  // a clear sweep zeroes register k on its k-th edge.
  logic [15:0] m_regs [8];
  int          m_clr_left = 0;

  logic [15:0] pat [8] = '{16'h0000, 16'h0001, 16'h0010, 16'h0011,
                           16'h0100, 16'h0101, 16'h0110, 16'h0111};

  function automatic vec_t mk(logic wv, logic [2:0] wa, logic [15:0] wd,
                              logic [2:0] as, logic [2:0] bs,
                              logic [15:0] ea, logic [15:0] eb, logic er);
    vec_t v;
    v.wv = wv; v.wa = wa; v.wd = wd; v.as = as; v.bs = bs;
    v.ea = ea; v.eb = eb; v.er = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
    m_clr_left = 0;
  endtask

  task automatic m_edge();
    if (m_clr_left > 0) begin
      m_regs[8 - m_clr_left] = 16'h0;
      m_clr_left--;
    end else begin
      if (wr_valid) m_regs[wr_addr] = wr_data;
      if (clr_req) m_clr_left = 8;
    end
  endtask

  task automatic tick();
    m_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic v, input logic [2:0] a, input logic [15:0] d);
    wr_valid = v;
    wr_addr  = a;
    wr_data  = d;
  endtask

  initial begin
    m_reset();

    // During reset
    #2;
    check("rst_ready", {15'h0, wr_ready}, 16'h1);
    check("rst_busy", {15'h0, clr_busy}, 16'h0);
    check("rst_rd_a", rd_a_data, 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: all registers read 0 after reset
    for (int i = 0; i < 8; i++) begin
      rd_a_sel = 3'(i);
      rd_b_sel = 3'(7 - i);
      #1;
      check("t1_rd_a", rd_a_data, 16'h0);
      check("t1_rd_b", rd_b_data, 16'h0);
      check("t1_ready", {15'h0, wr_ready}, 16'h1);
      check("t1_busy", {15'h0, clr_busy}, 16'h0);
      tick();
    end

    // 2: back-to-back writes, then read sweep with offset port B
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1'b1, 3'(i), pat[i], 3'((i + 7) % 8), 3'(i),
                        (i == 0) ? 16'h0 : pat[(i + 7) % 8], 16'h0, 1'b1));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1'b0, 3'd0, 16'h0, 3'(i), 3'((i + 3) % 8),
                        pat[i], pat[(i + 3) % 8], 1'b1));
    // 3: bypass of r5 then committed value
    vecs.push_back(mk(1'b1, 3'd5, 16'hBEEF, 3'd5, 3'd5, pat[5], pat[5], 1'b1));
    vecs.push_back(mk(1'b0, 3'd0, 16'h0, 3'd5, 3'd5, 16'hBEEF, 16'hBEEF, 1'b1));
    vecs.push_back(mk(1'b0, 3'd0, 16'h0, 3'd5, 3'd5, 16'hBEEF, 16'hBEEF, 1'b1));
    vecs.push_back(mk(1'b0, 3'd0, 16'h0, 3'd5, 3'd5, 16'hBEEF, 16'hBEEF, 1'b1));
    // 4: consecutive writes to r3
    vecs.push_back(mk(1'b1, 3'd3, 16'h1234, 3'd3, 3'd3, pat[3], pat[3], 1'b1));
    vecs.push_back(mk(1'b1, 3'd3, 16'h5678, 3'd3, 3'd0, 16'h1234, pat[0], 1'b1));
    vecs.push_back(mk(1'b0, 3'd0, 16'h0, 3'd3, 3'd5, 16'h5678, 16'hBEEF, 1'b1));
    vecs.push_back(mk(1'b0, 3'd0, 16'h0, 3'd3, 3'd3, 16'h5678, 16'h5678, 1'b1));

    foreach (vecs[k]) begin
      drive_wr(vecs[k].wv, vecs[k].wa, vecs[k].wd);
      rd_a_sel = vecs[k].as;
      rd_b_sel = vecs[k].bs;
      #1;
      check("tbl_rd_a", rd_a_data, vecs[k].ea);
      check("tbl_rd_b", rd_b_data, vecs[k].eb);
      check("tbl_ready", {15'h0, wr_ready}, {15'h0, vecs[k].er});
      tick();
    end
    drive_wr(1'b0, 3'd0, 16'h0);

    // 5: clear with simultaneous write; writes during the sweep are dropped
    drive_wr(1'b1, 3'd2, 16'hAAAA);
    tick();
    drive_wr(1'b1, 3'd6, 16'h5555);
    clr_req = 1'b1;
    #1;
    check("t5_ready_pre", {15'h0, wr_ready}, 16'h1);
    check("t5_busy_pre", {15'h0, clr_busy}, 16'h0);
    tick();
    for (int c = 0; c < 8; c++) begin
      drive_wr(1'b1, 3'd1, 16'hFFFF);
      clr_req  = (c < 4);
      rd_a_sel = 3'd6;
      rd_b_sel = 3'd2;
      #1;
      check("t5_busy", {15'h0, clr_busy}, 16'h1);
      check("t5_ready", {15'h0, wr_ready}, 16'h0);
      check("t5_r6", rd_a_data, (c <= 6) ? 16'h5555 : 16'h0);
      check("t5_r2", rd_b_data, (c <= 2) ? 16'hAAAA : 16'h0);
      tick();
    end
    drive_wr(1'b0, 3'd0, 16'h0);
    clr_req = 1'b0;
    #1;
    check("t5_busy_post", {15'h0, clr_busy}, 16'h0);
    check("t5_ready_post", {15'h0, wr_ready}, 16'h1);
    for (int i = 0; i < 8; i++) begin
      rd_a_sel = 3'(i);
      rd_b_sel = 3'((i + 1) % 8);
      #1;
      check("t5_zero_a", rd_a_data, 16'h0);
      check("t5_zero_b", rd_b_data, 16'h0);
      tick();
    end

    // 6: clear-wins on the first edge, then reset in CLEAR cycle 4
    drive_wr(1'b1, 3'd7, 16'h7777);
    tick();
    drive_wr(1'b1, 3'd0, 16'h0F0F);
    clr_req = 1'b1;
    tick();
    drive_wr(1'b0, 3'd0, 16'h0);
    clr_req  = 1'b0;
    rd_a_sel = 3'd0;
    #1;
    check("t6_bypass_r0", rd_a_data, 16'h0F0F);
    tick();
    #1;
    check("t6_clear_wins", rd_a_data, 16'h0);
    tick();
    tick();
    tick();
    rd_a_sel = 3'd7;
    rd_b_sel = 3'd7;
    #1;
    check("t6_r7_pre", rd_a_data, 16'h7777);
    check("t6_busy_pre", {15'h0, clr_busy}, 16'h1);
    rst_n = 1'b0;
    m_reset();
    #1;
    check("t6_rst_busy", {15'h0, clr_busy}, 16'h0);
    check("t6_rst_ready", {15'h0, wr_ready}, 16'h1);
    check("t6_rst_rd_a", rd_a_data, 16'h0);
    check("t6_rst_rd_b", rd_b_data, 16'h0);
    #1;
    rst_n = 1'b1;
    drive_wr(1'b1, 3'd4, 16'h4444);
    rd_a_sel = 3'd4;
    tick();
    drive_wr(1'b0, 3'd0, 16'h0);
    #1;
    check("t6_wr_bypass", rd_a_data, 16'h4444);
    check("t6_busy_idle", {15'h0, clr_busy}, 16'h0);
    tick();
    check("t6_wr_commit", rd_a_data, 16'h4444);

    // Random traffic against the visible-value model
    for (int n = 0; n < 600; n++) begin
      drive_wr($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 16'($urandom));
      clr_req  = ($urandom_range(0, 29) == 0);
      rd_a_sel = 3'($urandom_range(0, 7));
      rd_b_sel = 3'($urandom_range(0, 7));
      #1;
      check("rnd_rd_a", rd_a_data, m_regs[rd_a_sel]);
      check("rnd_rd_b", rd_b_data, m_regs[rd_b_sel]);
      check("rnd_ready", {15'h0, wr_ready}, {15'h0, m_clr_left == 0});
      check("rnd_busy", {15'h0, clr_busy}, {15'h0, m_clr_left > 0});
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
